pulse_train_gen: RTL

Parametrised programmable pulse-train generator, the next generation of the fixed 48/48 pulse block. Produces a registered waveform on `pulse` with run-time high/low phase lengths, operating either in burst mode (N pulses, then done) or in continuous mode until stopped. It is driven by the shared testbench `clock` and is the standard stimulus and strobe source for sequential exercises.

---
 rtl/pulse_gen_pkg.sv | 13 +
 rtl/pulse_train_gen_phase_counter.sv | 27 ++
 rtl/pulse_train_gen.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pulse_gen_pkg.sv
// rtl/pulse_gen_pkg.sv - shared state encoding and mode constants for pulse_train_gen
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic MODE_BURST = 1'b0;
    localparam logic MODE_CONT  = 1'b1;

endpackage

// File: rtl/pulse_train_gen_phase_counter.sv
// rtl/pulse_train_gen_phase_counter.sv - loadable down-counter timing one HIGH or LOW phase
module phase_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] value,
    output logic             expire
);

    // A zero length is stretched to one cycle so every phase lasts at least one clock.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            value <= '0;
        end else if (load) begin
            value <= (load_value == '0) ? CNT_W'(1) : load_value;
        end else if (value != '0) begin
            value <= value - CNT_W'(1);
        end
    end

    // Asserted during the final cycle of the phase; the FSM switches on the following edge.
    assign expire = (value == CNT_W'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - programmable burst/continuous pulse-train generator (optional PULSE_GEN_POLARITY_EN)
module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int   CNT_W    = 8,
    parameter int   NUM_W    = 8,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [NUM_W-1:0] num_pulses,
`ifdef PULSE_GEN_POLARITY_EN
    input  logic             polarity,
`endif
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_idx
);

    state_t             state, state_next;
    logic               mode_q;
    logic [CNT_W-1:0]   high_q, low_q;
    logic [NUM_W-1:0]   num_q;
    logic [NUM_W-1:0]   idx_next;
    logic               done_next, pulse_next, launch;
    logic               cnt_load, cnt_expire;
    logic [CNT_W-1:0]   cnt_load_value, cnt_value;
    logic               pol_next, active_lvl;

`ifdef PULSE_GEN_POLARITY_EN
    logic pol_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pol_q <= 1'b0;
        end else if (launch) begin
            pol_q <= polarity;
        end
    end

    assign pol_next = launch ? polarity : pol_q;
`else
    assign pol_next = 1'b0;
`endif

    // Inverted polarity swaps the active and idle levels for the whole run.
    assign active_lvl = ~IDLE_LVL ^ pol_next;

    phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .value      (cnt_value),
        .expire     (cnt_expire)
    );

    always_comb begin
        state_next     = state;
        idx_next       = pulse_idx;
        done_next      = 1'b0;
        launch         = 1'b0;
        cnt_load       = 1'b0;
        cnt_load_value = high_q;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    launch   = 1'b1;
                    idx_next = '0;
                    if (mode == MODE_BURST && num_pulses == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next     = HIGH;
                        cnt_load       = 1'b1;
                        cnt_load_value = high_len;
                    end
                end
            end
            HIGH: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (cnt_expire) begin
                    idx_next = pulse_idx + NUM_W'(1);
                    if (mode_q == MODE_BURST && idx_next == num_q) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next     = LOW;
                        cnt_load       = 1'b1;
                        cnt_load_value = low_q;
                    end
                end
            end
            LOW: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (cnt_expire) begin
                    state_next     = HIGH;
                    cnt_load       = 1'b1;
                    cnt_load_value = high_q;
                end
            end
            default: state_next = IDLE;
        endcase
        pulse_next = (state_next == HIGH) ? active_lvl : ~active_lvl;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            pulse     <= IDLE_LVL;
            done      <= 1'b0;
            pulse_idx <= '0;
            mode_q    <= MODE_BURST;
            high_q    <= '0;
            low_q     <= '0;
            num_q     <= '0;
        end else begin
            state     <= state_next;
            pulse     <= pulse_next;
            done      <= done_next;
            pulse_idx <= idx_next;
            if (launch) begin
                mode_q <= mode;
                high_q <= high_len;
                low_q  <= low_len;
                num_q  <= num_pulses;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
